// File: rtl/blur_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blur_cfg_pkg
// Brief    : Shared register map, response codes and helpers for the blur
//            accelerator configuration slave.
// Revision : 1.0  initial release
// ============================================================================
package blur_cfg_pkg;

  // Byte offsets within the 256-byte register window
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_ENABLE = 8'h40;
  localparam logic [7:0] ADDR_WEIGHT = 8'h44;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CTRL register bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  // Merge a new word into an old one, byte lane by byte lane
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cfg_regfile
// Brief    : Byte-strobed ENABLE and WEIGHT[] storage with address decode
//            and read multiplexer.
// Revision : 1.0  initial release
// ============================================================================
module cfg_regfile #(
  parameter int ADDR_W      = 32,
  parameter int NUM_WEIGHTS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic                     wr_hit,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_hit,
  output logic                     enable,
  output logic [NUM_WEIGHTS*32-1:0] weights
);
  import blur_cfg_pkg::*;

  localparam int c_w_first = int'(ADDR_WEIGHT[7:2]);

  logic r_enable;
  logic w_wr_win;
  logic w_rd_win;
  logic w_unused_addr_bits;

  // Addresses above the 256-byte window never alias into the map
  assign w_wr_win = (wr_addr[ADDR_W-1:8] == '0);
  assign w_rd_win = (rd_addr[ADDR_W-1:8] == '0);

  // Byte-offset bits carry no decode information
  assign w_unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  function automatic logic decode_hit(input logic [ADDR_W-1:0] a);
    int idx;
    idx = int'(a[7:2]);
    return (a[ADDR_W-1:8] == '0) &&
           ((a[7:2] == ADDR_ENABLE[7:2]) ||
            ((idx >= c_w_first) && (idx < c_w_first + NUM_WEIGHTS)));
  endfunction

  assign wr_hit = decode_hit(wr_addr);
  assign enable = r_enable;

  // ENABLE keeps only bit 0; the remaining bits of the word are not stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= 1'b0;
    end else if (wr_en && w_wr_win && (wr_addr[7:2] == ADDR_ENABLE[7:2]) && wr_strb[0]) begin
      r_enable <= wr_data[0];
    end
  end

  for (genvar gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_weight
    localparam logic [5:0] c_idx = 6'(c_w_first + gi);
    logic [31:0] r_val;

    // One weight word, updated only on the lanes the master strobes
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= '0;
      end else if (wr_en && w_wr_win && (wr_addr[7:2] == c_idx)) begin
        r_val <= apply_wstrb(r_val, wr_data, wr_strb);
      end
    end

    assign weights[32*gi +: 32] = r_val;
  end

  // Read multiplexer; unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    rd_hit  = decode_hit(rd_addr);
    if (w_rd_win && (rd_addr[7:2] == ADDR_ENABLE[7:2])) begin
      rd_data = {31'b0, r_enable};
    end
    for (int i = 0; i < NUM_WEIGHTS; i++) begin
      if (w_rd_win && (int'(rd_addr[7:2]) == c_w_first + i)) begin
        rd_data = weights[32*i +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_lite_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_cfg_slave
// Brief    : AXI4-Lite responder for the blur accelerator CTRL/STATUS/ENABLE/
//            WEIGHT registers; drives start/enable/weights into the core.
// Revision : 1.0  initial release
// ============================================================================
module axi_lite_cfg_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_WEIGHTS = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_W-1:0]         WDATA,
  input  logic [DATA_W/8-1:0]       WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_W-1:0]         ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_W-1:0]         RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      ap_start,
  input  logic                      ap_done,
  input  logic                      ap_idle,
  output logic                      enable,
  output logic [NUM_WEIGHTS*32-1:0] weights
);
  import blur_cfg_pkg::*;

  logic                r_live;
  logic                r_aw_full, r_w_full, r_bvalid, r_rvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [1:0]          r_bresp, r_rresp;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ap_start, r_busy, r_done;
  logic [15:0]         r_frame_cnt;

  logic        w_do_write, w_wr_ctrl, w_wr_status, w_ctrl_wr, w_start, w_done_clr;
  logic        w_rd_ctrl, w_rd_status, w_rf_wr_hit, w_rf_rd_hit;
  logic [31:0] w_rf_rd_data, w_rd_data;
  logic [1:0]  w_rd_resp, w_wr_resp;

  // Write commits once both address and data are held
  assign w_do_write  = r_aw_full && r_w_full;
  assign w_wr_ctrl   = (r_awaddr[ADDR_W-1:8] == '0) && (r_awaddr[7:2] == ADDR_CTRL[7:2]);
  assign w_wr_status = (r_awaddr[ADDR_W-1:8] == '0) && (r_awaddr[7:2] == ADDR_STATUS[7:2]);
  assign w_rd_ctrl   = (ARADDR[ADDR_W-1:8] == '0) && (ARADDR[7:2] == ADDR_CTRL[7:2]);
  assign w_rd_status = (ARADDR[ADDR_W-1:8] == '0) && (ARADDR[7:2] == ADDR_STATUS[7:2]);
  assign w_wr_resp   = (w_wr_ctrl || w_wr_status || w_rf_wr_hit) ? RESP_OKAY : RESP_SLVERR;

  assign w_ctrl_wr  = w_do_write && w_wr_ctrl && r_wstrb[0];
  assign w_start    = w_ctrl_wr && r_wdata[CTRL_START_BIT] && !r_busy;
  assign w_done_clr = w_ctrl_wr && r_wdata[CTRL_DONE_BIT];

  // READY stays low while reset is asserted and for the first cycle after it
  assign AWREADY  = r_live && !r_aw_full && !r_bvalid;
  assign WREADY   = r_live && !r_w_full && !r_bvalid;
  assign ARREADY  = r_live && !r_rvalid;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign ap_start = r_ap_start;

  cfg_regfile #(
    .ADDR_W      (ADDR_W),
    .NUM_WEIGHTS (NUM_WEIGHTS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (w_do_write),
    .wr_addr (r_awaddr),
    .wr_data (r_wdata),
    .wr_strb (r_wstrb),
    .wr_hit  (w_rf_wr_hit),
    .rd_addr (ARADDR),
    .rd_data (w_rf_rd_data),
    .rd_hit  (w_rf_rd_hit),
    .enable  (enable),
    .weights (weights)
  );

  // Read data selection across CTRL, STATUS and the register file
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (w_rd_ctrl) begin
      w_rd_data = {30'b0, r_done, r_ap_start};
    end else if (w_rd_status) begin
      w_rd_data = {r_frame_cnt, 14'b0, ap_idle, r_busy};
    end else if (w_rf_rd_hit) begin
      w_rd_data = w_rf_rd_data;
    end else begin
      w_rd_resp = RESP_SLVERR;
    end
  end

  // Gate for the READY outputs, low throughout reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // Write channel capture, commit and response handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (AWVALID && AWREADY) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= AWADDR;
      end
      if (WVALID && WREADY) begin
        r_w_full <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
      if (w_do_write) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: data registered at the AR handshake, held until RREADY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (ARVALID && ARREADY) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Core control: start pulse, busy/done tracking and frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ap_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_ap_start <= w_start;
      if (w_start)      r_busy <= 1'b1;
      else if (ap_done) r_busy <= 1'b0;
      // A completion in the same cycle as a clear leaves done set
      if (ap_done)                      r_done <= 1'b1;
      else if (w_start || w_done_clr)   r_done <= 1'b0;
      if (ap_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_cfg_slave
// Brief    : Directed self-checking bench for axi_lite_cfg_slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_cfg_slave;

  localparam int LIMIT = 50;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]   WSTRB;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]   BRESP, RRESP;
  logic         ap_start, ap_done, ap_idle, enable;
  logic [319:0] weights;

  int checks = 0;
  int fails = 0;
  int start_cnt = 0;
  logic [31:0] exp_w [10];

  always #5 clk = ~clk;

  // Counts the cycles in which ap_start is high
  always @(negedge clk) if (ap_start === 1'b1) start_cnt++;

  axi_lite_cfg_slave dut (
    .clk(clk), .reset_n(reset_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .enable(enable), .weights(weights)
  );

  // All bus tasks start and end at posedge + 1
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    AWADDR = a; AWVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!AWREADY && n < LIMIT);
    if (!AWREADY) begin checks++; fails++; $display("FAIL aw_timeout addr=%h", a); end
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!WREADY && n < LIMIT);
    if (!WREADY) begin checks++; fails++; $display("FAIL w_timeout data=%h", d); end
    @(posedge clk); #1;
    WVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    BREADY = 1'b1;
    do begin @(negedge clk); n++; end while (!BVALID && n < LIMIT);
    if (!BVALID) begin checks++; fails++; $display("FAIL b_timeout got BVALID=0 want 1"); end
    resp = BRESP;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    ARADDR = a; ARVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!ARREADY && n < LIMIT);
    if (!ARREADY) begin checks++; fails++; $display("FAIL ar_timeout addr=%h", a); end
    @(posedge clk); #1;
    ARVALID = 1'b0;
  endtask

  task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    RREADY = 1'b1;
    do begin @(negedge clk); n++; end while (!RVALID && n < LIMIT);
    if (!RVALID) begin checks++; fails++; $display("FAIL r_timeout got RVALID=0 want 1"); end
    d = RDATA; r = RRESP;
    @(posedge clk); #1;
    RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    send_ar(a);
    wait_r(d, r);
  endtask

  task automatic pulse_done();
    ap_done = 1'b1;
    @(posedge clk); #1;
    ap_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, ap_start, enable} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl got %b want 0000000",
        {AWREADY, WREADY, ARREADY, BVALID, RVALID, ap_start, enable});
    end
    checks++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      fails++; $display("FAIL reset_data got %h want 0", {BRESP, RRESP, RDATA});
    end
    checks++;
    if (weights !== '0) begin fails++; $display("FAIL reset_weights got %h want 0", weights); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      fails++; $display("FAIL ready_after_reset got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_regs();
    logic [31:0] vals [10];
    logic [31:0] d;
    logic [1:0]  r;
    vals = '{32'd3, 32'd2, 32'd1, 32'd7, 32'd6, 32'd5, 32'd4, 32'd10, 32'd9, 32'd8};
    axi_write(32'h40, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin fails++; $display("FAIL enable_bresp got %b want 00", r); end
    for (int i = 0; i < 10; i++) begin
      exp_w[i] = vals[i];
      axi_write(32'h44 + 4*i, vals[i], 4'hF, r);
      checks++;
      if (r !== 2'b00) begin fails++; $display("FAIL weight_bresp[%0d] got %b want 00", i, r); end
    end
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h1 || r !== 2'b00) begin
      fails++; $display("FAIL enable_read got %h/%b want 00000001/00", d, r);
    end
    for (int i = 0; i < 10; i++) begin
      axi_read(32'h44 + 4*i, d, r);
      checks++;
      if (d !== exp_w[i] || r !== 2'b00) begin
        fails++; $display("FAIL weight_read[%0d] got %h/%b want %h/00", i, d, r, exp_w[i]);
      end
    end
    checks++;
    if (enable !== 1'b1) begin fails++; $display("FAIL enable_pin got %b want 1", enable); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (weights[32*i +: 32] !== exp_w[i]) begin
        fails++; $display("FAIL weights_bus[%0d] got %h want %h", i, weights[32*i +: 32], exp_w[i]);
      end
    end
  endtask

  task automatic test_order();
    logic [31:0] d;
    logic [1:0]  r;
    logic        early;
    // Address two cycles ahead of data
    send_aw(32'h4C);
    early = 1'b0;
    repeat (2) begin @(negedge clk); if (BVALID !== 1'b0) early = 1'b1; @(posedge clk); #1; end
    checks++;
    if (early) begin fails++; $display("FAIL aw_first_early_b got BVALID=1 want 0"); end
    send_w(32'h55, 4'hF);
    wait_b(r);
    checks++;
    if (r !== 2'b00) begin fails++; $display("FAIL aw_first_bresp got %b want 00", r); end
    @(negedge clk);
    checks++;
    if (BVALID !== 1'b0) begin fails++; $display("FAIL aw_first_single_b got BVALID=%b want 0", BVALID); end
    @(posedge clk); #1;
    axi_read(32'h4C, d, r);
    checks++;
    if (d !== 32'h55) begin fails++; $display("FAIL aw_first_value got %h want 00000055", d); end
    // Data two cycles ahead of address
    send_w(32'hA5, 4'hF);
    early = 1'b0;
    repeat (2) begin @(negedge clk); if (BVALID !== 1'b0) early = 1'b1; @(posedge clk); #1; end
    checks++;
    if (early) begin fails++; $display("FAIL w_first_early_b got BVALID=1 want 0"); end
    send_aw(32'h4C);
    wait_b(r);
    checks++;
    if (r !== 2'b00) begin fails++; $display("FAIL w_first_bresp got %b want 00", r); end
    exp_w[2] = 32'hA5;
    axi_read(32'h4C, d, r);
    checks++;
    if (d !== 32'hA5) begin fails++; $display("FAIL w_first_value got %h want 000000a5", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h44, 32'hAABBCCDD, 4'hF, r);
    axi_write(32'h44, 32'h11223344, 4'b0101, r);
    exp_w[0] = 32'hAA22CC44;
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'hAA22CC44) begin fails++; $display("FAIL strobe_merge got %h want aa22cc44", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    logic [1:0]  r;
    int          s0;
    ap_idle = 1'b0;
    s0 = start_cnt;
    axi_write(32'h00, 32'h1, 4'hF, r);
    @(posedge clk); #1;
    checks++;
    if (start_cnt - s0 !== 1) begin fails++; $display("FAIL start_pulse got %0d cycles want 1", start_cnt - s0); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h00000001) begin fails++; $display("FAIL status_busy got %h want 00000001", d); end
    ap_idle = 1'b1;
    pulse_done();
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h2) begin fails++; $display("FAIL ctrl_done got %h want 00000002", d); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h00010002) begin fails++; $display("FAIL status_frame got %h want 00010002", d); end
    axi_write(32'h00, 32'h2, 4'hF, r);
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL ctrl_w1c got %h want 00000000", d); end
    // Start again, then a second start while busy must be ignored
    s0 = start_cnt;
    axi_write(32'h00, 32'h1, 4'hF, r);
    axi_write(32'h00, 32'h1, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin fails++; $display("FAIL busy_start_bresp got %b want 00", r); end
    @(posedge clk); #1;
    checks++;
    if (start_cnt - s0 !== 1) begin fails++; $display("FAIL busy_start_ignored got %0d pulses want 1", start_cnt - s0); end
    pulse_done();
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h00020002) begin fails++; $display("FAIL status_frame2 got %h want 00020002", d); end
    axi_write(32'h00, 32'h2, 4'hF, r);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    int          s0;
    s0 = start_cnt;
    axi_read(32'h100, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL unmapped_read got %h/%b want 00000000/10", d, r); end
    axi_write(32'h100, 32'h3, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin fails++; $display("FAIL unmapped_bresp got %b want 10", r); end
    @(posedge clk); #1;
    checks++;
    if (start_cnt !== s0) begin fails++; $display("FAIL unmapped_no_start got %0d want %0d", start_cnt, s0); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL unmapped_ctrl got %h want 00000000", d); end
    axi_write(32'h144, 32'hDEAD, 4'hF, r);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (weights[32*i +: 32] !== exp_w[i]) begin
        fails++; $display("FAIL unmapped_weights[%0d] got %h want %h", i, weights[32*i +: 32], exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0]  r;
    logic        bad;
    int          n;
    fork
      send_aw(32'h50);
      send_w(32'h77, 4'hF);
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!BVALID && n < LIMIT);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (BVALID !== 1'b1 || BRESP !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("FAIL b_hold got BVALID=%b BRESP=%b want 1/00", BVALID, BRESP); end
    @(posedge clk); #1;
    wait_b(r);
    exp_w[3] = 32'h77;
    send_ar(32'h50);
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < LIMIT);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (RVALID !== 1'b1 || RDATA !== 32'h77 || RRESP !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("FAIL r_hold got %b/%h/%b want 1/00000077/00", RVALID, RDATA, RRESP); end
    @(posedge clk); #1;
    wait_r(d, r);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    logic        bad;
    send_aw(32'h40);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, enable} !== 6'b0) begin
      fails++; $display("FAIL mid_reset_ctl got %b want 000000",
        {AWREADY, WREADY, ARREADY, BVALID, RVALID, enable});
    end
    checks++;
    if (weights !== '0) begin fails++; $display("FAIL mid_reset_weights got %h want 0", weights); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    // Lone data must not pair with the discarded address
    send_w(32'h1, 4'hF);
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (BVALID !== 1'b0) bad = 1'b1; @(posedge clk); #1; end
    checks++;
    if (bad) begin fails++; $display("FAIL mid_reset_stale_aw got BVALID=1 want 0"); end
    send_aw(32'h44);
    wait_b(r);
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_enable got %h want 00000000", d); end
    axi_read(32'h44, d, r);
    checks++;
    if (d !== 32'h1) begin fails++; $display("FAIL mid_reset_weight0 got %h want 00000001", d); end
  endtask

  initial begin
    reset_n = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    ap_done = 1'b0; ap_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_regs();
    test_order();
    test_strobe();
    test_ctrl();
    test_unmapped();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
